// File: rtl/imm_gen_stage.sv
// Immediate generation for the decode path: extracts and sign-extends RV immediates,
// forms pc + imm, and registers the result behind a valid/ready handshake.
module imm_gen_stage #(
    parameter int unsigned XLEN = 32,
    parameter bit          SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [2:0]      imm_sel,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc_target,
    output logic            sel_err
);

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_J = 3'd3,
        FMT_U = 3'd4,
        FMT_Z = 3'd5
    } fmt_e;

    logic [31:0]     imm32;
    logic            sel_bad;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] tgt_ext;
    logic            unused_opcode;

    assign unused_opcode = ^inst[6:0];

    // Every format is built as a 32-bit value whose bit 31 is the required sign,
    // so a single signed widening covers both XLEN choices (Z keeps bit 31 clear).
    always_comb begin
        imm32   = '0;
        sel_bad = 1'b0;
        case (imm_sel)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'b0};
            FMT_Z:   imm32 = {27'b0, inst[19:15]};
            default: sel_bad = 1'b1;
        endcase
    end

    assign imm_ext = XLEN'($signed(imm32));
    assign tgt_ext = pc + imm_ext;

    if (SKID) begin : g_skid
        logic            m_valid, k_valid, rdy_q;
        logic [XLEN-1:0] m_imm, m_tgt, k_imm, k_tgt;
        logic            m_err, k_err;
        logic            in_xfer, out_xfer;

        assign in_xfer  = in_valid & rdy_q;
        assign out_xfer = m_valid & out_ready;

        // K only fills while M is stalled, so in_ready can be a flop tracking !K.valid.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                m_valid <= 1'b0;
                k_valid <= 1'b0;
                rdy_q   <= 1'b1;
                m_imm   <= '0;
                m_tgt   <= '0;
                m_err   <= 1'b0;
                k_imm   <= '0;
                k_tgt   <= '0;
                k_err   <= 1'b0;
            end else if (out_xfer) begin
                if (k_valid) begin
                    m_imm   <= k_imm;
                    m_tgt   <= k_tgt;
                    m_err   <= k_err;
                    k_valid <= 1'b0;
                    rdy_q   <= 1'b1;
                end else if (in_xfer) begin
                    m_imm <= imm_ext;
                    m_tgt <= tgt_ext;
                    m_err <= sel_bad;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (in_xfer) begin
                if (!m_valid) begin
                    m_valid <= 1'b1;
                    m_imm   <= imm_ext;
                    m_tgt   <= tgt_ext;
                    m_err   <= sel_bad;
                end else begin
                    k_valid <= 1'b1;
                    k_imm   <= imm_ext;
                    k_tgt   <= tgt_ext;
                    k_err   <= sel_bad;
                    rdy_q   <= 1'b0;
                end
            end
        end

        assign in_ready  = rdy_q;
        assign out_valid = m_valid;
        assign imm       = m_imm;
        assign pc_target = m_tgt;
        assign sel_err   = m_err;
    end else begin : g_pipe
        logic            m_valid;
        logic [XLEN-1:0] m_imm, m_tgt;
        logic            m_err;
        logic            rdy, in_xfer;

        assign rdy     = !m_valid | out_ready;
        assign in_xfer = in_valid & rdy;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                m_valid <= 1'b0;
                m_imm   <= '0;
                m_tgt   <= '0;
                m_err   <= 1'b0;
            end else if (in_xfer) begin
                m_valid <= 1'b1;
                m_imm   <= imm_ext;
                m_tgt   <= tgt_ext;
                m_err   <= sel_bad;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end

        assign in_ready  = rdy;
        assign out_valid = m_valid;
        assign imm       = m_imm;
        assign pc_target = m_tgt;
        assign sel_err   = m_err;
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed and streaming checks of imm_gen_stage: 32-bit with and without skid buffer,
// plus a 64-bit instance; one stimulus process drives whichever instance dsel picks.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [31:0] inst;
    logic [2:0]  imm_sel;
    logic [63:0] pc;
    int          dsel;

    always #5 clk = ~clk;

    logic        a_in_ready, a_out_valid, a_err;
    logic [31:0] a_imm, a_tgt;
    logic        b_in_ready, b_out_valid, b_err;
    logic [31:0] b_imm, b_tgt;
    logic        c_in_ready, c_out_valid, c_err;
    logic [63:0] c_imm, c_tgt;

    imm_gen_stage #(.XLEN(32), .SKID(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (dsel == 0)), .in_ready(a_in_ready),
        .inst(inst), .imm_sel(imm_sel), .pc(pc[31:0]), .out_valid(a_out_valid),
        .out_ready(out_ready), .imm(a_imm), .pc_target(a_tgt), .sel_err(a_err)
    );

    imm_gen_stage #(.XLEN(32), .SKID(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (dsel == 1)), .in_ready(b_in_ready),
        .inst(inst), .imm_sel(imm_sel), .pc(pc[31:0]), .out_valid(b_out_valid),
        .out_ready(out_ready), .imm(b_imm), .pc_target(b_tgt), .sel_err(b_err)
    );

    imm_gen_stage #(.XLEN(64), .SKID(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (dsel == 2)), .in_ready(c_in_ready),
        .inst(inst), .imm_sel(imm_sel), .pc(pc), .out_valid(c_out_valid),
        .out_ready(out_ready), .imm(c_imm), .pc_target(c_tgt), .sel_err(c_err)
    );

    logic        o_in_ready, o_valid, o_err;
    logic [63:0] o_imm, o_tgt;

    always_comb begin
        o_in_ready = a_in_ready;
        o_valid    = a_out_valid;
        o_err      = a_err;
        o_imm      = {32'b0, a_imm};
        o_tgt      = {32'b0, a_tgt};
        if (dsel == 1) begin
            o_in_ready = b_in_ready;
            o_valid    = b_out_valid;
            o_err      = b_err;
            o_imm      = {32'b0, b_imm};
            o_tgt      = {32'b0, b_tgt};
        end else if (dsel == 2) begin
            o_in_ready = c_in_ready;
            o_valid    = c_out_valid;
            o_err      = c_err;
            o_imm      = c_imm;
            o_tgt      = c_tgt;
        end
    end

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        err;
    } beat_t;

    beat_t q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    out_cnt = 0;
    int    last_out = 0;
    bit    have_last = 1'b0;
    bit    contig = 1'b0;

    function automatic beat_t model(input logic [31:0] i, input logic [2:0] s,
                                    input logic [63:0] p, input bit x64);
        beat_t       b;
        logic [31:0] v;
        logic [63:0] e;
        b.err = 1'b0;
        case (s)
            3'd0:    v = {{20{i[31]}}, i[31:20]};
            3'd1:    v = {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd4:    v = {i[31:12], 12'b0};
            3'd5:    v = {27'b0, i[19:15]};
            default: begin v = '0; b.err = 1'b1; end
        endcase
        e     = {{32{v[31]}}, v};
        b.tgt = e + p;
        if (!x64) begin
            e[63:32]     = '0;
            b.tgt[63:32] = '0;
        end
        b.imm = e;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard work for the upcoming posedge, evaluated at the negedge before it.
    task automatic monitor();
        beat_t exp;
        cyc++;
        if (!rst_n) begin
            q.delete();
            have_last = 1'b0;
        end else begin
            if (o_valid && out_ready) begin
                checks++;
                assert (q.size() > 0) else begin
                    errors++;
                    $error("FAIL sb_underflow observed=output expected=no_output");
                end
                if (q.size() > 0) begin
                    exp = q.pop_front();
                    checks++;
                    assert (o_imm === exp.imm && o_tgt === exp.tgt && o_err === exp.err) else begin
                        errors++;
                        $error("FAIL sb_beat observed=%h/%h/%b expected=%h/%h/%b",
                               o_imm, o_tgt, o_err, exp.imm, exp.tgt, exp.err);
                    end
                end
                if (contig && have_last) begin
                    checks++;
                    assert (last_out + 1 == cyc) else begin
                        errors++;
                        $error("FAIL sb_gap observed=%0d expected=%0d", cyc, last_out + 1);
                    end
                end
                last_out  = cyc;
                have_last = 1'b1;
                out_cnt++;
            end
            if (in_valid && o_in_ready)
                q.push_back(model(inst, imm_sel, pc, dsel == 2));
        end
    endtask

    task automatic neg();
        @(negedge clk);
        monitor();
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [2:0] s, input logic [63:0] p,
                        input bit rnd, output int waits);
        bit done = 1'b0;
        inst     = i;
        imm_sel  = s;
        pc       = p;
        in_valid = 1'b1;
        waits    = 0;
        for (int n = 0; n < 64 && !done; n++) begin
            neg();
            if (o_in_ready) done = 1'b1;
            pos();
            if (!done) begin
                waits++;
                if (rnd) out_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic expect_beat(input string tag, input logic [63:0] ei, input logic [63:0] et,
                               input logic ee);
        neg();
        chk({tag, "_valid"}, {63'b0, o_valid}, 64'd1);
        chk({tag, "_imm"}, o_imm, ei);
        chk({tag, "_tgt"}, o_tgt, et);
        chk({tag, "_err"}, {63'b0, o_err}, {63'b0, ee});
        pos();
    endtask

    initial begin
        int w;
        int start;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        inst      = '0;
        imm_sel   = '0;
        pc        = '0;
        dsel      = 0;

        neg(); pos(); neg();
        chk("rst_valid", {63'b0, o_valid}, 64'd0);
        chk("rst_ready", {63'b0, o_in_ready}, 64'd1);
        chk("rst_imm", o_imm, 64'd0);
        pos();
        rst_n = 1'b1;

        // directed formats on the skid instance
        send(32'hFFF00093, 3'd0, 64'h100, 1'b0, w); in_valid = 1'b0;
        expect_beat("i_type", 64'hFFFFFFFF, 64'h000000FF, 1'b0);
        send(32'hFE112C23, 3'd1, 64'h0, 1'b0, w); in_valid = 1'b0;
        expect_beat("s_type", 64'hFFFFFFF8, 64'hFFFFFFF8, 1'b0);
        send(32'hFE000EE3, 3'd2, 64'h100, 1'b0, w); in_valid = 1'b0;
        expect_beat("b_type", 64'hFFFFFFFC, 64'h000000FC, 1'b0);
        send(32'h0080006F, 3'd3, 64'h200, 1'b0, w); in_valid = 1'b0;
        expect_beat("j_type", 64'h8, 64'h208, 1'b0);
        send(32'h123450B7, 3'd4, 64'h0, 1'b0, w); in_valid = 1'b0;
        expect_beat("u_type", 64'h12345000, 64'h12345000, 1'b0);
        send(32'h000FD073, 3'd5, 64'h10, 1'b0, w); in_valid = 1'b0;
        expect_beat("z_type", 64'h1F, 64'h2F, 1'b0);
        send(32'h12345678, 3'd7, 64'h40, 1'b0, w); in_valid = 1'b0;
        expect_beat("rsv_sel", 64'h0, 64'h40, 1'b1);

        // backpressure: A to M, B to K, C held
        out_ready = 1'b0;
        inst = 32'hFFF00093; imm_sel = 3'd0; pc = 64'h100; in_valid = 1'b1;
        neg(); chk("bp_rdy_a", {63'b0, o_in_ready}, 64'd1); pos();
        inst = 32'hFE112C23; imm_sel = 3'd1; pc = 64'h0;
        neg(); chk("bp_rdy_b", {63'b0, o_in_ready}, 64'd1); pos();
        inst = 32'h0080006F; imm_sel = 3'd3; pc = 64'h200;
        for (int k = 0; k < 3; k++) begin
            neg();
            chk("bp_rdy_c", {63'b0, o_in_ready}, 64'd0);
            chk("bp_hold_valid", {63'b0, o_valid}, 64'd1);
            chk("bp_hold_imm", o_imm, 64'hFFFFFFFF);
            chk("bp_hold_tgt", o_tgt, 64'h000000FF);
            pos();
        end
        out_ready = 1'b1;
        neg(); chk("bp_out_a", o_imm, 64'hFFFFFFFF); pos();
        neg(); chk("bp_rdy_free", {63'b0, o_in_ready}, 64'd1); chk("bp_out_b", o_imm, 64'hFFFFFFF8); pos();
        in_valid = 1'b0;
        neg(); chk("bp_out_c_valid", {63'b0, o_valid}, 64'd1); chk("bp_out_c", o_tgt, 64'h208); pos();
        neg(); chk("bp_empty", {63'b0, o_valid}, 64'd0); pos();

        // reset while two beats are held and a third is offered
        out_ready = 1'b0;
        send(32'h123450B7, 3'd4, 64'h0, 1'b0, w);
        send(32'h000FD073, 3'd5, 64'h0, 1'b0, w);
        inst = 32'hFFF00093; imm_sel = 3'd0;
        rst_n = 1'b0;
        neg(); pos();
        neg();
        chk("mrst_valid", {63'b0, o_valid}, 64'd0);
        chk("mrst_imm", o_imm, 64'd0);
        chk("mrst_tgt", o_tgt, 64'd0);
        chk("mrst_ready", {63'b0, o_in_ready}, 64'd1);
        pos();
        neg(); chk("mrst_ignore_in", {63'b0, o_valid}, 64'd0); pos();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;

        // combinational in_ready of the plain pipeline register
        dsel = 1; out_ready = 1'b0;
        send(32'hFE000EE3, 3'd2, 64'h100, 1'b0, w);
        inst = 32'h0080006F; imm_sel = 3'd3; pc = 64'h200;
        neg(); chk("p0_rdy_stall", {63'b0, o_in_ready}, 64'd0); chk("p0_imm", o_imm, 64'hFFFFFFFC); pos();
        out_ready = 1'b1;
        neg(); chk("p0_rdy_pass", {63'b0, o_in_ready}, 64'd1); pos();
        in_valid = 1'b0;
        neg(); chk("p0_next", o_tgt, 64'h208); pos();

        // streaming on both 32-bit instances
        for (int d = 0; d < 2; d++) begin
            dsel = d; out_ready = 1'b1;
            contig = 1'b1; have_last = 1'b0; start = out_cnt;
            for (int n = 0; n < 16; n++) begin
                send($urandom, 3'($urandom_range(0, 7)), {32'b0, $urandom}, 1'b0, w);
                chk("stream_nowait", 64'(w), 64'd0);
            end
            in_valid = 1'b0;
            neg(); pos(); neg(); pos();
            contig = 1'b0;
            chk("stream_count", 64'(out_cnt - start), 64'd16);
            chk("stream_drained", 64'(q.size()), 64'd0);

            start = out_cnt;
            for (int n = 0; n < 16; n++) begin
                out_ready = 1'($urandom_range(0, 1));
                send($urandom, 3'($urandom_range(0, 7)), {32'b0, $urandom}, 1'b1, w);
            end
            in_valid = 1'b0; out_ready = 1'b1;
            for (int n = 0; n < 20 && q.size() > 0; n++) begin
                neg(); pos();
            end
            neg(); pos();
            chk("rand_count", 64'(out_cnt - start), 64'd16);
            chk("rand_drained", 64'(q.size()), 64'd0);
        end

        // 64-bit instance
        dsel = 2; out_ready = 1'b1;
        send(32'hFFF00093, 3'd0, 64'h0, 1'b0, w); in_valid = 1'b0;
        expect_beat("x64_i", 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send(32'h800000B7, 3'd4, 64'h1000, 1'b0, w); in_valid = 1'b0;
        expect_beat("x64_u", 64'hFFFFFFFF80000000, 64'hFFFFFFFF80001000, 1'b0);
        send(32'h000FD073, 3'd5, 64'hFFFFFFFFFFFFFFF0, 1'b0, w); in_valid = 1'b0;
        expect_beat("x64_z", 64'h1F, 64'h000000000000000F, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
